// File: rtl/huffman_gen.sv
// huffman_gen: counts a frame of symbol indices, then builds Huffman codes
// by repeated two-minimum merges and publishes per-symbol codes and masks.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   gray_valid         qualifies gray_data; one contiguous run is one frame
//   gray_data          symbol index, legal values 1..NSYM
//   busy               high from first accepted sample through code_valid
//   CNT_valid, CNT     one-cycle pulse with per-symbol counts
//   code_valid, HC, M  one-cycle pulse with per-symbol codes and masks
//   err                sticky: [0] out-of-range symbol, [1] sample dropped
module huffman_gen #(
  parameter int NSYM   = 6,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gray_valid,
  input  logic [7:0]               gray_data,
  output logic                     busy,
  output logic                     CNT_valid,
  output logic [NSYM*CNT_W-1:0]    CNT,
  output logic                     code_valid,
  output logic [NSYM*CODE_W-1:0]   HC,
  output logic [NSYM*CODE_W-1:0]   M,
  output logic [1:0]               err
);

  localparam int SUM_W = CNT_W + 3;
  localparam int IDX_W = 4;
  localparam int DW    = $clog2(CODE_W + 1);
  localparam int KEY_W = NSYM + 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, PUBLISH, SCAN, MERGE, CODE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q  [NSYM];
  logic [SUM_W-1:0]  nsum_q [NSYM];
  logic [NSYM-1:0]   nmsk_q [NSYM];
  logic [NSYM-1:0]   nmrg_q;
  logic [CODE_W-1:0] code_q [NSYM];
  logic [CODE_W-1:0] len_q  [NSYM];
  logic [DW-1:0]     dep_q  [NSYM];
  logic [CODE_W-1:0] code_d [NSYM];
  logic [CODE_W-1:0] len_d  [NSYM];
  logic [DW-1:0]     dep_d  [NSYM];

  logic [IDX_W-1:0] m_q, idx_q, a_pos, b_pos;
  logic [SUM_W-1:0] a_sum, b_sum;
  logic             a_mrg, b_mrg, b_vld;
  logic [NSYM-1:0]  a_msk, b_msk;

  logic [SUM_W-1:0] cur_sum;
  logic             cur_mrg;
  logic [NSYM-1:0]  cur_msk;
  logic [KEY_W-1:0] cur_key, a_key, b_key;
  logic [IDX_W-1:0] lo, hi;

  logic [NSYM*CNT_W-1:0]  cnt_pk;
  logic [NSYM*CODE_W-1:0] hc_nx, m_nx;

  logic       start, in_rng, drop, scan_last, fin;
  logic [2:0] sidx;

  // Tie-break key: merged nodes rank highest, then lower symbols,
  // so the member set is laid out with symbol 1 most significant.
  function automatic logic [KEY_W-1:0] tkey(
    input logic            mrg,
    input logic [NSYM-1:0] msk
  );
    logic [KEY_W-1:0] k;
    k[NSYM] = mrg;
    for (int i = 0; i < NSYM; i++) k[NSYM-1-i] = msk[i];
    return k;
  endfunction

  // x ranks below y: smaller sum, or equal sum with larger key
  function automatic logic less(
    input logic [SUM_W-1:0] xs,
    input logic [KEY_W-1:0] xk,
    input logic [SUM_W-1:0] ys,
    input logic [KEY_W-1:0] yk
  );
    return (xs < ys) || ((xs == ys) && (xk > yk));
  endfunction

  function automatic logic [CODE_W-1:0] onehot(input logic [DW-1:0] d);
    return CODE_W'(1) << d;
  endfunction

  assign start  = gray_valid &&
                  ((state_q == IDLE) || (state_q == DONE));
  assign in_rng = (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
  assign sidx   = 3'(gray_data - 8'd1);
  assign drop   = gray_valid &&
                  ((state_q == PUBLISH) || (state_q == SCAN) ||
                   (state_q == MERGE) || (state_q == CODE));
  assign scan_last = (idx_q == m_q - IDX_W'(1));
  assign fin       = (state_q == CODE) && (m_q == IDX_W'(1));
  assign lo        = (a_pos < b_pos) ? a_pos : b_pos;
  assign hi        = (a_pos < b_pos) ? b_pos : a_pos;
  assign cur_key   = tkey(cur_mrg, cur_msk);
  assign a_key     = tkey(a_mrg, a_msk);
  assign b_key     = tkey(b_mrg, b_msk);

  always_comb begin
    cur_sum = '0;
    cur_mrg = 1'b0;
    cur_msk = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_sum = nsum_q[i];
        cur_mrg = nmrg_q[i];
        cur_msk = nmsk_q[i];
      end
    end
  end

  // A members take a 1, B members a 0, at each symbol's current depth
  always_comb begin
    for (int s = 0; s < NSYM; s++) begin
      code_d[s] = code_q[s];
      len_d[s]  = len_q[s];
      dep_d[s]  = dep_q[s];
      if (a_msk[s] || b_msk[s]) begin
        len_d[s] = len_q[s] | onehot(dep_q[s]);
        dep_d[s] = dep_q[s] + DW'(1);
      end
      if (a_msk[s]) code_d[s] = code_q[s] | onehot(dep_q[s]);
    end
  end

  always_comb begin
    cnt_pk = '0;
    hc_nx  = '0;
    m_nx   = '0;
    for (int i = 0; i < NSYM; i++) begin
      cnt_pk[i*CNT_W +: CNT_W] = cnt_q[i];
      hc_nx[i*CODE_W +: CODE_W] = code_d[i];
      m_nx[i*CODE_W +: CODE_W]  = len_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (gray_valid) state_d = COUNT;
      COUNT:      if (!gray_valid) state_d = PUBLISH;
      PUBLISH:    state_d = SCAN;
      SCAN:       if (scan_last) state_d = MERGE;
      MERGE:      state_d = CODE;
      CODE:       state_d = fin ? DONE : SCAN;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      CNT_valid  <= 1'b0;
      CNT        <= '0;
      code_valid <= 1'b0;
      HC         <= '0;
      M          <= '0;
      err        <= '0;
      m_q        <= '0;
      idx_q      <= '0;
      a_pos      <= '0;
      b_pos      <= '0;
      a_sum      <= '0;
      b_sum      <= '0;
      a_mrg      <= 1'b0;
      b_mrg      <= 1'b0;
      a_msk      <= '0;
      b_msk      <= '0;
      b_vld      <= 1'b0;
      nmrg_q     <= '0;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i]  <= '0;
        nsum_q[i] <= '0;
        nmsk_q[i] <= '0;
        code_q[i] <= '0;
        len_q[i]  <= '0;
        dep_q[i]  <= '0;
      end
    end else begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      if (drop) err[1] <= 1'b1;

      if (start) begin
        busy <= 1'b1;
        err  <= {1'b0, !in_rng};
        for (int i = 0; i < NSYM; i++) begin
          cnt_q[i]  <= (in_rng && (sidx == 3'(i))) ? CNT_W'(1) : '0;
          code_q[i] <= '0;
          len_q[i]  <= '0;
          dep_q[i]  <= '0;
        end
      end else if (state_q == DONE) begin
        busy <= 1'b0;
      end

      if (state_q == COUNT) begin
        if (gray_valid) begin
          if (!in_rng) err[0] <= 1'b1;
          for (int i = 0; i < NSYM; i++) begin
            if (in_rng && (sidx == 3'(i)) && (cnt_q[i] != '1))
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          CNT       <= cnt_pk;
          CNT_valid <= 1'b1;
        end
      end

      if (state_q == PUBLISH) begin
        m_q    <= IDX_W'(NSYM);
        idx_q  <= '0;
        nmrg_q <= '0;
        for (int i = 0; i < NSYM; i++) begin
          nsum_q[i] <= SUM_W'(cnt_q[i]);
          nmsk_q[i] <= NSYM'(1) << i;
        end
      end

      if (state_q == SCAN) begin
        idx_q <= idx_q + IDX_W'(1);
        if (idx_q == '0) begin
          a_pos <= idx_q;
          a_sum <= cur_sum;
          a_mrg <= cur_mrg;
          a_msk <= cur_msk;
          b_vld <= 1'b0;
        end else if (less(cur_sum, cur_key, a_sum, a_key)) begin
          b_pos <= a_pos;
          b_sum <= a_sum;
          b_mrg <= a_mrg;
          b_msk <= a_msk;
          b_vld <= 1'b1;
          a_pos <= idx_q;
          a_sum <= cur_sum;
          a_mrg <= cur_mrg;
          a_msk <= cur_msk;
        end else if (!b_vld || less(cur_sum, cur_key, b_sum, b_key)) begin
          b_pos <= idx_q;
          b_sum <= cur_sum;
          b_mrg <= cur_mrg;
          b_msk <= cur_msk;
          b_vld <= 1'b1;
        end
      end

      if (state_q == MERGE) begin
        m_q <= m_q - IDX_W'(1);
        for (int i = 0; i < NSYM - 1; i++) begin
          if (IDX_W'(i) >= hi) begin
            nsum_q[i] <= nsum_q[i+1];
            nmrg_q[i] <= nmrg_q[i+1];
            nmsk_q[i] <= nmsk_q[i+1];
          end
        end
        for (int i = 0; i < NSYM; i++) begin
          if (IDX_W'(i) == lo) begin
            nsum_q[i] <= a_sum + b_sum;
            nmrg_q[i] <= 1'b1;
            nmsk_q[i] <= a_msk | b_msk;
          end
        end
      end

      if (state_q == CODE) begin
        idx_q <= '0;
        for (int s = 0; s < NSYM; s++) begin
          code_q[s] <= code_d[s];
          len_q[s]  <= len_d[s];
          dep_q[s]  <= dep_d[s];
        end
        if (fin) begin
          code_valid <= 1'b1;
          HC         <= hc_nx;
          M          <= m_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_gen.sv
// tb_huffman_gen: directed frames against a 6-symbol and a 2-symbol
// generator sharing the same input stream.
module tb_huffman_gen;

  logic        clk;
  logic        reset;
  logic        gray_valid;
  logic [7:0]  gray_data;

  logic        busy6, cntv6, cdv6;
  logic [47:0] cnt6, hc6, m6;
  logic [1:0]  err6;

  logic        busy2, cntv2, cdv2;
  logic [7:0]  cnt2;
  logic [15:0] hc2, m2;
  logic [1:0]  err2;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] fr[$];

  huffman_gen #(.NSYM(6), .CNT_W(8), .CODE_W(8)) u6 (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .busy       (busy6),
    .CNT_valid  (cntv6),
    .CNT        (cnt6),
    .code_valid (cdv6),
    .HC         (hc6),
    .M          (m6),
    .err        (err6)
  );

  huffman_gen #(.NSYM(2), .CNT_W(4), .CODE_W(8)) u2 (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .busy       (busy2),
    .CNT_valid  (cntv2),
    .CNT        (cnt2),
    .code_valid (cdv2),
    .HC         (hc2),
    .M          (m2),
    .err        (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mk_basic();
    fr.delete();
    for (int s = 1; s <= 6; s++)
      repeat (s) fr.push_back(8'(s));
  endtask

  task automatic send_fr(output int t_last);
    t_last = 0;
    foreach (fr[i]) begin
      @(posedge clk);
      #1;
      gray_valid = 1'b1;
      gray_data  = fr[i];
      t_last     = cyc;
    end
  endtask

  // Ends the frame and watches both builds; optional drop/reset injection
  task automatic build(
    input  int   inj,
    input  int   rst_at,
    output int   cv6,
    output int   cd6,
    output int   cv2,
    output int   cd2,
    output logic b6
  );
    cv6 = -1;
    cd6 = -1;
    cv2 = -1;
    cd2 = -1;
    b6  = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      gray_valid = (cyc == inj);
      gray_data  = (cyc == inj) ? 8'd3 : 8'd0;
      reset      = (cyc == rst_at);
      @(negedge clk);
      if (cntv6 && cv6 < 0) cv6 = cyc;
      if (cntv2 && cv2 < 0) cv2 = cyc;
      if (cdv2 && cd2 < 0) cd2 = cyc;
      if (cdv6 && cd6 < 0) begin
        cd6 = cyc;
        b6  = busy6;
      end
      if (cd6 >= 0 && cd2 >= 0) break;
    end
    gray_valid = 1'b0;
    reset      = 1'b0;
  endtask

  localparam logic [47:0] CNT_B = 48'h06_05_04_03_02_01;
  localparam logic [47:0] HC_B  = 48'h00_02_03_02_06_07;
  localparam logic [47:0] M_B   = 48'h03_03_03_07_0F_0F;

  initial begin
    int   t, cv6, cd6, cv2, cd2;
    logic b6;

    reset      = 1'b1;
    gray_valid = 1'b0;
    gray_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cnt6", 64'(cnt6), 64'd0);
    chk("rst_hc6", 64'(hc6), 64'd0);
    chk("rst_m6", 64'(m6), 64'd0);
    chk("rst_ctl6", 64'({busy6, cntv6, cdv6, err6}), 64'd0);
    chk("rst_out2", 64'({busy2, cntv2, cdv2, err2, cnt2}), 64'd0);

    // basic build
    mk_basic();
    send_fr(t);
    @(negedge clk);
    chk("busy_up", 64'(busy6), 64'd1);
    build(-1, -1, cv6, cd6, cv2, cd2, b6);
    chk("b_cv_t", 64'(cv6), 64'(t + 2));
    chk("b_cd_t", 64'(cd6), 64'(t + 33));
    chk("b_busy_cd", 64'(b6), 64'd1);
    chk("b_cnt", 64'(cnt6), 64'(CNT_B));
    chk("b_hc", 64'(hc6), 64'(HC_B));
    chk("b_m", 64'(m6), 64'(M_B));
    chk("b_err", 64'(err6), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_dn", 64'(busy6), 64'd0);

    // out-of-range symbols
    fr.delete();
    fr.push_back(8'd0);
    repeat (5) fr.push_back(8'd3);
    fr.push_back(8'd7);
    repeat (5) fr.push_back(8'd3);
    send_fr(t);
    build(-1, -1, cv6, cd6, cv2, cd2, b6);
    chk("oor_cnt", 64'(cnt6), 64'h00_00_00_0A_00_00);
    chk("oor_err", 64'(err6), 64'd1);
    chk("oor_cd_t", 64'(cd6), 64'(t + 33));

    // back-to-back: starts the cycle after code_valid
    mk_basic();
    send_fr(t);
    build(-1, -1, cv6, cd6, cv2, cd2, b6);
    chk("bb_cnt", 64'(cnt6), 64'(CNT_B));
    chk("bb_hc", 64'(hc6), 64'(HC_B));
    chk("bb_m", 64'(m6), 64'(M_B));
    chk("bb_err", 64'(err6), 64'd0);
    chk("bb_cd_t", 64'(cd6), 64'(t + 33));

    // sample dropped while scanning
    mk_basic();
    send_fr(t);
    build(t + 5, -1, cv6, cd6, cv2, cd2, b6);
    chk("drop_err", 64'(err6), 64'd2);
    chk("drop_hc", 64'(hc6), 64'(HC_B));
    chk("drop_m", 64'(m6), 64'(M_B));
    chk("drop_cd_t", 64'(cd6), 64'(t + 33));

    // reset during the first merge
    mk_basic();
    send_fr(t);
    build(-1, t + 9, cv6, cd6, cv2, cd2, b6);
    chk("mr_cnt", 64'(cnt6), 64'd0);
    chk("mr_hc", 64'(hc6), 64'd0);
    chk("mr_m", 64'(m6), 64'd0);
    chk("mr_ctl", 64'({busy6, cntv6, cdv6, err6}), 64'd0);
    chk("mr_nopulse", 64'(cd6), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mr_out2", 64'({hc2, m2, cnt2}), 64'd0);

    // saturation at CNT_W=4 on the two-symbol unit
    fr.delete();
    repeat (20) fr.push_back(8'd2);
    send_fr(t);
    build(-1, -1, cv6, cd6, cv2, cd2, b6);
    chk("sat_cnt2", 64'(cnt2), 64'hF0);
    chk("sat_cv2_t", 64'(cv2), 64'(t + 2));
    chk("sat_cd2_t", 64'(cd2), 64'(t + 7));
    chk("sat_hc2", 64'(hc2), 64'h0001);
    chk("sat_m2", 64'(m2), 64'h0101);
    chk("sat_err2", 64'(err2), 64'd0);
    chk("sat_cnt6", 64'(cnt6), 64'h00_00_00_00_14_00);
    chk("sat_cd6_t", 64'(cd6), 64'(t + 33));

    // equal counts on two symbols
    fr.delete();
    repeat (3) begin
      fr.push_back(8'd1);
      fr.push_back(8'd2);
    end
    send_fr(t);
    build(-1, -1, cv6, cd6, cv2, cd2, b6);
    chk("eq_cnt2", 64'(cnt2), 64'h33);
    chk("eq_hc2", 64'(hc2), 64'h0001);
    chk("eq_m2", 64'(m2), 64'h0101);
    chk("eq_cd2_t", 64'(cd2), 64'(t + 7));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
